// File: rtl/fp_add_align_pipe.sv
// fp_add_align_pipe: two-stage front end of the floating-point adder.
// Stage 1 unpacks both operands, applies the subtract control to B's sign,
// orders the operands by magnitude and classifies NaN/infinity.
// Stage 2 right-aligns the smaller significand, keeping guard/round/sticky bits.
// The stages pass data over a valid/ready handshake and accept one operation per cycle.
module fp_add_align_pipe #(
    parameter int EXPO_WIDTH = 8,
    parameter int MENT_WIDTH = 23,
    parameter int DATA_WIDTH = EXPO_WIDTH + MENT_WIDTH + 1
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  in_valid_in,
    output logic                  in_ready_out,
    input  logic [DATA_WIDTH-1:0] floating1_in,
    input  logic [DATA_WIDTH-1:0] floating2_in,
    input  logic                  op_sub_in,
    output logic                  out_valid_out,
    input  logic                  out_ready_in,
    output logic [MENT_WIDTH+3:0] bigger_mant_out,
    output logic [MENT_WIDTH+3:0] smaller_mant_out,
    output logic [EXPO_WIDTH-1:0] bigger_exponent_out,
    output logic [EXPO_WIDTH-1:0] exp_diff_out,
    output logic                  sign_out,
    output logic                  eff_sub_out,
    output logic                  nan_out,
    output logic                  inf_out
);

    localparam int SIG_WIDTH = MENT_WIDTH + 1;  // hidden bit + stored mantissa
    localparam int ALN_WIDTH = MENT_WIDTH + 4;  // significand + G, R, S

    // ---------------- stage 1 combinational: unpack / compare / swap ----------------
    logic                  sign_a, sign_b_eff;
    logic [EXPO_WIDTH-1:0] exp_a, exp_b, eexp_a, eexp_b;
    logic [MENT_WIDTH-1:0] mant_a, mant_b;
    logic [SIG_WIDTH-1:0]  sig_a, sig_b;
    logic                  nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic                  a_ge_b, mag_eq, eff_sub;
    logic [EXPO_WIDTH-1:0] big_eexp, small_eexp;

    logic [SIG_WIDTH-1:0]  s1_big_sig_d,   s1_big_sig_q;
    logic [SIG_WIDTH-1:0]  s1_small_sig_d, s1_small_sig_q;
    logic [EXPO_WIDTH-1:0] s1_big_exp_d,   s1_big_exp_q;
    logic [EXPO_WIDTH-1:0] s1_diff_d,      s1_diff_q;
    logic                  s1_sign_d,      s1_sign_q;
    logic                  s1_eff_sub_d,   s1_eff_sub_q;
    logic                  s1_nan_d,       s1_nan_q;
    logic                  s1_inf_d,       s1_inf_q;
    logic                  v1_d,           v1_q;

    // ---------------- stage 2: aligned result registers ----------------
    logic [ALN_WIDTH-1:0]  aln_ext, aln_lost_mask, aln_result;
    logic [ALN_WIDTH-1:0]  s2_big_mant_q, s2_small_mant_q;
    logic [EXPO_WIDTH-1:0] s2_big_exp_q, s2_diff_q;
    logic                  s2_sign_q, s2_eff_sub_q, s2_nan_q, s2_inf_q;
    logic                  v2_d, v2_q;
    logic                  s2_load;

    // Handshake: stage 2 advances when empty or drained; stage 1 whenever there is room downstream.
    always_comb begin
        s2_load      = !v2_q || out_ready_in;
        in_ready_out = !v1_q || s2_load;
        v1_d         = in_ready_out ? in_valid_in : v1_q;
        v2_d         = s2_load ? v1_q : v2_q;
    end

    // Unpack both operands, pick the larger magnitude and classify special values.
    always_comb begin
        sign_a     = floating1_in[DATA_WIDTH-1];
        sign_b_eff = floating2_in[DATA_WIDTH-1] ^ op_sub_in;
        exp_a      = floating1_in[DATA_WIDTH-2 -: EXPO_WIDTH];
        exp_b      = floating2_in[DATA_WIDTH-2 -: EXPO_WIDTH];
        mant_a     = floating1_in[MENT_WIDTH-1:0];
        mant_b     = floating2_in[MENT_WIDTH-1:0];

        // Denormals use effective exponent 1 with a cleared hidden bit.
        eexp_a = (exp_a == '0) ? EXPO_WIDTH'(1) : exp_a;
        eexp_b = (exp_b == '0) ? EXPO_WIDTH'(1) : exp_b;
        sig_a  = {exp_a != '0, mant_a};
        sig_b  = {exp_b != '0, mant_b};

        nan_a  = (&exp_a) && (mant_a != '0);
        nan_b  = (&exp_b) && (mant_b != '0);
        inf_a  = (&exp_a) && (mant_a == '0);
        inf_b  = (&exp_b) && (mant_b == '0);
        zero_a = (exp_a == '0) && (mant_a == '0);
        zero_b = (exp_b == '0) && (mant_b == '0);

        eff_sub = sign_a ^ sign_b_eff;
        // The raw {exp, mant} field ordering equals magnitude ordering, denormals included.
        a_ge_b  = {exp_a, mant_a} >= {exp_b, mant_b};
        mag_eq  = {exp_a, mant_a} == {exp_b, mant_b};

        big_eexp       = a_ge_b ? eexp_a : eexp_b;
        small_eexp     = a_ge_b ? eexp_b : eexp_a;
        s1_big_sig_d   = a_ge_b ? sig_a  : sig_b;
        s1_small_sig_d = a_ge_b ? sig_b  : sig_a;
        s1_diff_d      = big_eexp - small_eexp;
        s1_eff_sub_d   = eff_sub;

        s1_nan_d = nan_a || nan_b || (inf_a && inf_b && eff_sub);
        s1_inf_d = !s1_nan_d && (inf_a || inf_b);
        s1_big_exp_d = (s1_nan_d || s1_inf_d) ? '1 : big_eexp;

        if (inf_a)                  s1_sign_d = sign_a;
        else if (inf_b)             s1_sign_d = sign_b_eff;
        else if (zero_a && zero_b)  s1_sign_d = sign_a & sign_b_eff;
        else if (mag_eq && eff_sub) s1_sign_d = 1'b0;   // exact cancellation gives +0
        else                        s1_sign_d = a_ge_b ? sign_a : sign_b_eff;
    end

    // Stage 1 registers: capture an accepted operand pair.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            v1_q           <= 1'b0;
            s1_big_sig_q   <= '0;
            s1_small_sig_q <= '0;
            s1_big_exp_q   <= '0;
            s1_diff_q      <= '0;
            s1_sign_q      <= 1'b0;
            s1_eff_sub_q   <= 1'b0;
            s1_nan_q       <= 1'b0;
            s1_inf_q       <= 1'b0;
        end else begin
            v1_q <= v1_d;
            if (in_ready_out && in_valid_in) begin
                s1_big_sig_q   <= s1_big_sig_d;
                s1_small_sig_q <= s1_small_sig_d;
                s1_big_exp_q   <= s1_big_exp_d;
                s1_diff_q      <= s1_diff_d;
                s1_sign_q      <= s1_sign_d;
                s1_eff_sub_q   <= s1_eff_sub_d;
                s1_nan_q       <= s1_nan_d;
                s1_inf_q       <= s1_inf_d;
            end
        end
    end

    // Right-align the smaller significand; every bit shifted out below S is ORed into S.
    always_comb begin
        aln_ext       = {s1_small_sig_q, 3'b000};
        aln_lost_mask = ~({ALN_WIDTH{1'b1}} << s1_diff_q);
        if (int'(s1_diff_q) >= ALN_WIDTH) begin
            aln_result = {{(ALN_WIDTH-1){1'b0}}, |s1_small_sig_q};
        end else begin
            aln_result = (aln_ext >> s1_diff_q)
                       | {{(ALN_WIDTH-1){1'b0}}, |(aln_ext & aln_lost_mask)};
        end
    end

    // Stage 2 registers: outputs hold while the downstream stage stalls.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            v2_q            <= 1'b0;
            s2_big_mant_q   <= '0;
            s2_small_mant_q <= '0;
            s2_big_exp_q    <= '0;
            s2_diff_q       <= '0;
            s2_sign_q       <= 1'b0;
            s2_eff_sub_q    <= 1'b0;
            s2_nan_q        <= 1'b0;
            s2_inf_q        <= 1'b0;
        end else begin
            v2_q <= v2_d;
            if (s2_load && v1_q) begin
                s2_big_mant_q   <= {s1_big_sig_q, 3'b000};
                s2_small_mant_q <= aln_result;
                s2_big_exp_q    <= s1_big_exp_q;
                s2_diff_q       <= s1_diff_q;
                s2_sign_q       <= s1_sign_q;
                s2_eff_sub_q    <= s1_eff_sub_q;
                s2_nan_q        <= s1_nan_q;
                s2_inf_q        <= s1_inf_q;
            end
        end
    end

    assign out_valid_out       = v2_q;
    assign bigger_mant_out     = s2_big_mant_q;
    assign smaller_mant_out    = s2_small_mant_q;
    assign bigger_exponent_out = s2_big_exp_q;
    assign exp_diff_out        = s2_diff_q;
    assign sign_out            = s2_sign_q;
    assign eff_sub_out         = s2_eff_sub_q;
    assign nan_out             = s2_nan_q;
    assign inf_out             = s2_inf_q;

endmodule
